execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- RV32I execute (EX) stage. Sits between decode and Data_Memory_Block.
- Applies operand forwarding and runs the ALU. Results are registered into the EX/MEM outputs that feed the memory stage: ans_ex, B_Bypass, seldmresult, dm_en, dm_rw and rw.
- Shifts run iteratively at 1 bit per cycle, with a stall handshake back to decode.
- Load-use hazards stall decode for one cycle and insert a bubble.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  decode presents an instruction.
- flush  in  1  squash the EX contents and the next output (branch redirect).
- rs1, rs2  in  REGW  source register indices.
- a_in, b_in  in  XLEN  register-file values for rs1 and rs2.
- imm_in  in  XLEN  sign-extended immediate.
- sel_imm  in  1  1 selects imm_in as ALU operand B.
- alu_op  in  4  operation code, defined in the package.
- rw_in  in  REGW  destination register; 0 means no writeback.
- seldmresult_in, dm_en_in, dm_rw_in  in  1 each  memory control, passed through.
- wb_rw  in  REGW  MEM-stage destination (rw_out of Data_Memory_Block).
- wb_data  in  XLEN  MEM-stage result (writedata of Data_Memory_Block).
- stall_out  out  1  decode must hold its current instruction.
- ans_ex  out  XLEN  ALU result; also the memory address.
- B_Bypass  out  XLEN  forwarded rs2 value, used as store data.
- seldmresult, dm_en, dm_rw  out  1 each  registered memory control.
- rw_out  out  REGW  registered destination register.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Shift counter is 0.
  - stall_out is 0.
- Bubble: every registered output is 0 (rw_out=0, dm_en=0, so no side effects).
- Forwarding, applied per source operand rs, only when rs!=0:
  - Priority 1: rw_out==rs and seldmresult==0 → use ans_ex.
  - Priority 2: wb_rw==rs → use wb_data.
  - Otherwise use a_in / b_in.
  - Operand B = sel_imm ? imm_in : forwarded rs2.
  - B_Bypass always takes the forwarded rs2.
- Load-use hazard:
  - Condition: IDLE, valid_in, rw_out!=0, seldmresult==1, and rw_out equals rs1 or rs2 (rs2 is checked regardless of sel_imm).
  - Response: stall_out=1 combinationally and a bubble is registered.
  - In the following cycle the value arrives through wb forwarding.
- ALU results, all arithmetic modulo 2^32:
  - ADD, SUB, XOR, OR, AND.
  - SLT / SLTU: signed / unsigned compare, result 0 or 1.
  - PASSB (LUI): result = operand B.
  - Undefined alu_op: result 0.
- Non-shift latency: 1 cycle. Accepted at edge N, outputs valid after edge N.
- Shift ops (SLL, SRL, SRA), shamt = opB[4:0]:
  - shamt=0: completes like a non-shift op (result = opA).
  - shamt=k>0: at edge N capture opA, k, op type and the control/rw/B_Bypass fields; register a bubble; go to SHIFT.
  - In SHIFT: stall_out=1, valid_in is ignored, one bit is shifted per cycle, the counter decrements, and bubbles are registered.
  - SRA fills with the sign bit; SRL and SLL fill with 0.
  - On the k-th SHIFT cycle (counter==1): register the result and captured fields at that edge, then return to IDLE.
  - Result appears after edge N+k.
  - The next instruction is accepted in cycle N+k+1 and may forward from ans_ex.
- FSM: IDLE → SHIFT on an accepted shift with k>0. SHIFT → IDLE at counter==1, or on flush.
- stall_out = (state==SHIFT) | load-use hazard.
- flush:
  - Has priority over everything except rst.
  - Registers a bubble, forces IDLE, clears the counter, and aborts the in-flight shift.
  - stall_out is 0 in the cycle after the flush edge.
- valid_in=0 in IDLE: a bubble is registered.

Decomposition:
- Package rv32_ex_pkg: ALU op constants and the bubble-field constants.
  - Codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - FSM state encoding: IDLE, SHIFT.
- One sub-module, serial_shifter: holds the operand and counter, with start, op, shamt, abort, done and result.
- Forwarding muxes and the ALU stay inline in execute_stage.

Test Plan:
- ADD, rs1=x1=5, rs2=x2=7, no hazards → ans_ex=12 one cycle later, rw_out=rw_in, stall_out=0 throughout.
- Back-to-back: ADD x3=x1+x2 (result 12), then SUB x4=x3-x1 with a_in stale=0 → ans_ex=7 (EX forwarding). A third instruction reading x3 while wb_rw=3 and wb_data=12 → uses 12.
- Load then use:
  - Stimulus: load to x5 (seldmresult_in=1), then ADD x6=x5+x0.
  - Required: stall_out=1 for exactly 1 cycle and one bubble (rw_out=0, dm_en=0).
  - Then, with wb_rw=5 and wb_data=0x55 → ans_ex=0x55.
- SRA, opA=0x80000000, shamt=4:
  - stall_out high for 4 cycles and 4 bubbles.
  - ans_ex=0xF8000000 after edge N+4.
  - A following instruction reading that destination gets the forwarded value.
- SLL with shamt=0 and opA=0x1234 → 1-cycle result 0x1234, no stall. SLTU 1 vs 0xFFFFFFFF → 1. SLT 1 vs 0xFFFFFFFF → 0.
- SRL shamt=31 with flush asserted in its 3rd SHIFT cycle → bubble, stall_out=0 next cycle, no shift result ever emitted. Asserting rst mid-shift → all outputs 0, IDLE.

Source files
------------

// File: rtl/rv32_ex_pkg.sv
// Shared types and constants for the RV32I execute stage: ALU op codes,
// FSM states and the registered EX/MEM output record.
package rv32_ex_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic [XLEN-1:0] ans;
        logic [XLEN-1:0] bbyp;
        logic            seldm;
        logic            dm_en;
        logic            dm_rw;
        logic [REGW-1:0] rw;
    } ex_out_t;

    // A bubble carries no destination and no memory enable, so it has no side effects.
    localparam ex_out_t EX_BUBBLE = '0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side request, MEM-stage feedback and EX/MEM result bundle.
interface execute_stage_if;
    import rv32_ex_pkg::*;

    logic            valid_in;
    logic            flush;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic [XLEN-1:0] imm_in;
    logic            sel_imm;
    logic [3:0]      alu_op;
    logic [REGW-1:0] rw_in;
    logic            seldmresult_in;
    logic            dm_en_in;
    logic            dm_rw_in;
    logic [REGW-1:0] wb_rw;
    logic [XLEN-1:0] wb_data;
    logic            stall_out;
    logic [XLEN-1:0] ans_ex;
    logic [XLEN-1:0] B_Bypass;
    logic            seldmresult;
    logic            dm_en;
    logic            dm_rw;
    logic [REGW-1:0] rw_out;

    modport master (
        output valid_in, flush, rs1, rs2, a_in, b_in, imm_in, sel_imm, alu_op,
               rw_in, seldmresult_in, dm_en_in, dm_rw_in, wb_rw, wb_data,
        input  stall_out, ans_ex, B_Bypass, seldmresult, dm_en, dm_rw, rw_out
    );

    modport slave (
        input  valid_in, flush, rs1, rs2, a_in, b_in, imm_in, sel_imm, alu_op,
               rw_in, seldmresult_in, dm_en_in, dm_rw_in, wb_rw, wb_data,
        output stall_out, ans_ex, B_Bypass, seldmresult, dm_en, dm_rw, rw_out
    );

endinterface

// File: rtl/serial_shifter.sv
// Iterative shifter: one bit per cycle. done_o flags the cycle whose shift
// completes the requested amount; result_o is that final shifted value.
module serial_shifter
    import rv32_ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [3:0]      op_i,
    input  logic [4:0]      shamt_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] step;

    // One-bit shift of the held operand; SRA replicates the sign bit.
    always_comb begin
        step = {1'b0, opnd_q[XLEN-1:1]};
        case (op_q)
            ALU_SLL: step = {opnd_q[XLEN-2:0], 1'b0};
            ALU_SRA: step = {opnd_q[XLEN-1], opnd_q[XLEN-1:1]};
            default: step = {1'b0, opnd_q[XLEN-1:1]};
        endcase
    end

    // Load on start, shift and count down while busy, clear on abort.
    always_comb begin
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            opnd_d = opnd_i;
            cnt_d  = shamt_i;
            op_d   = op_i;
        end else if (cnt_q != 5'd0) begin
            opnd_d = step;
            cnt_d  = cnt_q - 5'd1;
        end
    end

    assign done_o   = (cnt_q == 5'd1);
    assign result_o = step;

    // Counter is control and is reset; operand and op are plain data.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
        opnd_q <= opnd_d;
        op_q   <= op_d;
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, single-cycle ALU, iterative
// shifts with a decode stall, load-use bubble insertion, EX/MEM register.
module execute_stage
    import rv32_ex_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave ex_bus
);

    ex_state_e       state_q, state_d;
    ex_out_t         out_q, out_d;
    ex_out_t         hold_q, hold_d;
    ex_out_t         cur;
    logic [XLEN-1:0] rs1_val, rs2_val, opb, alu_res, shift_res;
    logic            hazard, accept, shift_start, shift_done;

    // EX result wins over MEM, except a load whose data is not yet in ans_ex.
    function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] rs,
                                           input logic [XLEN-1:0] rf_val,
                                           input ex_out_t         ex_q,
                                           input logic [REGW-1:0] mem_rw,
                                           input logic [XLEN-1:0] mem_data);
        if (rs != '0 && ex_q.rw == rs && !ex_q.seldm) return ex_q.ans;
        if (rs != '0 && mem_rw == rs) return mem_data;
        return rf_val;
    endfunction

    // Forwarded operands and the single-cycle ALU.
    always_comb begin
        rs1_val = fwd(ex_bus.rs1, ex_bus.a_in, out_q, ex_bus.wb_rw, ex_bus.wb_data);
        rs2_val = fwd(ex_bus.rs2, ex_bus.b_in, out_q, ex_bus.wb_rw, ex_bus.wb_data);
        opb     = ex_bus.sel_imm ? ex_bus.imm_in : rs2_val;
        alu_res = '0;
        case (ex_bus.alu_op)
            ALU_ADD:   alu_res = rs1_val + opb;
            ALU_SUB:   alu_res = rs1_val - opb;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(opb)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs1_val < opb};
            ALU_XOR:   alu_res = rs1_val ^ opb;
            ALU_OR:    alu_res = rs1_val | opb;
            ALU_AND:   alu_res = rs1_val & opb;
            ALU_PASSB: alu_res = opb;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = rs1_val;  // zero shift amount
            default:   alu_res = '0;
        endcase
    end

    assign hazard = (state_q == ST_IDLE) && ex_bus.valid_in && (out_q.rw != '0) &&
                    out_q.seldm && ((out_q.rw == ex_bus.rs1) || (out_q.rw == ex_bus.rs2));
    assign accept      = (state_q == ST_IDLE) && ex_bus.valid_in && !hazard && !ex_bus.flush;
    assign shift_start = accept && is_shift_op(ex_bus.alu_op) && (opb[4:0] != 5'd0);

    assign cur = '{ans: alu_res, bbyp: rs2_val, seldm: ex_bus.seldmresult_in,
                   dm_en: ex_bus.dm_en_in, dm_rw: ex_bus.dm_rw_in, rw: ex_bus.rw_in};

    serial_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (shift_start),
        .abort_i  (ex_bus.flush),
        .op_i     (ex_bus.alu_op),
        .shamt_i  (opb[4:0]),
        .opnd_i   (rs1_val),
        .done_o   (shift_done),
        .result_o (shift_res)
    );

    // Next state and next EX/MEM contents; anything not producing a result is a bubble.
    always_comb begin
        state_d = state_q;
        out_d   = EX_BUBBLE;
        hold_d  = hold_q;
        if (ex_bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (shift_start) begin
                        hold_d  = cur;
                        state_d = ST_SHIFT;
                    end else if (accept) begin
                        out_d = cur;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) begin
                        out_d     = hold_q;
                        out_d.ans = shift_res;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and EX/MEM register; the held shift fields need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= EX_BUBBLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
        hold_q <= hold_d;
    end

    assign ex_bus.stall_out   = (state_q == ST_SHIFT) || hazard;
    assign ex_bus.ans_ex      = out_q.ans;
    assign ex_bus.B_Bypass    = out_q.bbyp;
    assign ex_bus.seldmresult = out_q.seldm;
    assign ex_bus.dm_en       = out_q.dm_en;
    assign ex_bus.dm_rw       = out_q.dm_rw;
    assign ex_bus.rw_out      = out_q.rw;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios followed by random
// instructions, checked against a cycle-level behavioural model.
module tb_execute_stage;
    import rv32_ex_pkg::*;

    typedef struct {
        logic        rst, valid, flush, sel_imm, sd, en, rwr;
        logic [4:0]  rs1, rs2, rw, wb_rw;
        logic [3:0]  op;
        logic [31:0] a, b, imm, wb_data;
    } stim_t;

    typedef struct {
        logic [31:0] ans, bb;
        logic        sd, en, rwr;
        logic [4:0]  rw;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   out_idx = 0;

    res_t exp_out_q[$];
    logic exp_stall_q[$];

    res_t m_out, m_pend;
    logic m_busy;
    int   m_remain;
    logic last_stall;

    execute_stage_if bus();

    execute_stage dut (
        .clk    (clk),
        .rst    (rst),
        .ex_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << sh;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return $unsigned($signed(a) >>> sh);
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASSB: return b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
        if (rs == 0) return rf;
        if (m_out.rw == rs && !m_out.sd) return m_out.ans;
        if (s.wb_rw == rs) return s.wb_data;
        return rf;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t mk(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] a,
                                 input logic [4:0] rs2, input logic [31:0] b,
                                 input logic sel, input logic [31:0] imm, input logic [4:0] rw);
        stim_t s;
        s = idle();
        s.valid = 1'b1; s.op = op; s.rs1 = rs1; s.a = a; s.rs2 = rs2; s.b = b;
        s.sel_imm = sel; s.imm = imm; s.rw = rw;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), $urandom,
               5'($urandom_range(0, 7)));
        s.sd      = ($urandom_range(0, 3) == 0);
        s.en      = 1'($urandom_range(0, 1));
        s.rwr     = 1'($urandom_range(0, 1));
        s.wb_rw   = 5'($urandom_range(0, 7));
        s.wb_data = $urandom;
        return s;
    endfunction

    // Drive one cycle at the falling edge and queue what the DUT must show.
    task automatic step(input stim_t s);
        res_t        nxt, r;
        logic        hz;
        logic [31:0] opa, rs2v, opb;
        @(negedge clk);
        rst                = s.rst;
        bus.valid_in       = s.valid;
        bus.flush          = s.flush;
        bus.rs1            = s.rs1;
        bus.rs2            = s.rs2;
        bus.a_in           = s.a;
        bus.b_in           = s.b;
        bus.imm_in         = s.imm;
        bus.sel_imm        = s.sel_imm;
        bus.alu_op         = s.op;
        bus.rw_in          = s.rw;
        bus.seldmresult_in = s.sd;
        bus.dm_en_in       = s.en;
        bus.dm_rw_in       = s.rwr;
        bus.wb_rw          = s.wb_rw;
        bus.wb_data        = s.wb_data;

        hz = !m_busy && s.valid && (m_out.rw != 0) && m_out.sd &&
             (m_out.rw == s.rs1 || m_out.rw == s.rs2);
        last_stall = m_busy || hz;
        nxt = '{default: '0};
        if (s.rst || s.flush) begin
            m_busy   = 1'b0;
            m_remain = 0;
        end else if (m_busy) begin
            m_remain--;
            if (m_remain == 0) begin
                nxt    = m_pend;
                m_busy = 1'b0;
            end
        end else if (s.valid && !hz) begin
            opa   = ref_fwd(s.rs1, s.a, s);
            rs2v  = ref_fwd(s.rs2, s.b, s);
            opb   = s.sel_imm ? s.imm : rs2v;
            r.ans = ref_alu(s.op, opa, opb);
            r.bb  = rs2v; r.sd = s.sd; r.en = s.en; r.rwr = s.rwr; r.rw = s.rw;
            if ((s.op == ALU_SLL || s.op == ALU_SRL || s.op == ALU_SRA) && opb[4:0] != 0) begin
                m_pend   = r;
                m_remain = int'(opb[4:0]);
                m_busy   = 1'b1;
            end else begin
                nxt = r;
            end
        end
        m_out = nxt;
        exp_stall_q.push_back(last_stall);
        exp_out_q.push_back(nxt);
    endtask

    // Present an instruction until the model says decode is no longer held.
    task automatic issue(input stim_t s);
        int tries;
        tries = 0;
        do begin
            step(s);
            tries++;
        end while (last_stall && tries < 64);
        if (last_stall) begin
            checks++;
            errors++;
            $display("FAIL issue_bound: still stalled after %0d cycles, required release", tries);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // Registered EX/MEM outputs, one queued expectation per clock edge.
    always @(posedge clk) begin
        res_t e;
        #1;
        if (exp_out_q.size() != 0) begin
            e = exp_out_q.pop_front();
            checks++;
            if (bus.ans_ex !== e.ans || bus.B_Bypass !== e.bb || bus.seldmresult !== e.sd ||
                bus.dm_en !== e.en || bus.dm_rw !== e.rwr || bus.rw_out !== e.rw) begin
                errors++;
                $display("FAIL out[%0d]: got ans=%h bb=%h sd=%b en=%b rwr=%b rw=%0d, required ans=%h bb=%h sd=%b en=%b rwr=%b rw=%0d",
                         out_idx, bus.ans_ex, bus.B_Bypass, bus.seldmresult, bus.dm_en, bus.dm_rw,
                         bus.rw_out, e.ans, e.bb, e.sd, e.en, e.rwr, e.rw);
            end
            out_idx++;
        end
    end

    // Combinational stall, checked mid-cycle after inputs settle.
    always @(negedge clk) begin
        logic e;
        #1;
        if (exp_stall_q.size() != 0) begin
            e = exp_stall_q.pop_front();
            checks++;
            if (bus.stall_out !== e) begin
                errors++;
                $display("FAIL stall[%0d]: got %b, required %b", out_idx, bus.stall_out, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, u;
        m_out = '{default: '0};
        m_pend = '{default: '0};
        m_busy = 1'b0;
        m_remain = 0;
        last_stall = 1'b0;
        rst = 1'b1;
        bus.valid_in = 0; bus.flush = 0; bus.rs1 = 0; bus.rs2 = 0; bus.a_in = 0; bus.b_in = 0;
        bus.imm_in = 0; bus.sel_imm = 0; bus.alu_op = 0; bus.rw_in = 0; bus.seldmresult_in = 0;
        bus.dm_en_in = 0; bus.dm_rw_in = 0; bus.wb_rw = 0; bus.wb_data = 0;

        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        after_edge();
        chk("reset_ans", bus.ans_ex, 32'd0);
        chk("reset_rw", 32'(bus.rw_out), 32'd0);

        // ADD x3 = x1 + x2, then EX- and MEM-stage forwarding of x3
        step(mk(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 5'd3));
        after_edge();
        chk("add_ans", bus.ans_ex, 32'd12);
        chk("add_rw", 32'(bus.rw_out), 32'd3);
        step(mk(ALU_SUB, 5'd3, 32'd0, 5'd1, 32'd5, 1'b0, 32'd0, 5'd4));
        after_edge();
        chk("sub_exfwd", bus.ans_ex, 32'd7);
        s = mk(ALU_ADD, 5'd3, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd7);
        s.wb_rw = 5'd3; s.wb_data = 32'd12;
        step(s);
        after_edge();
        chk("add_wbfwd", bus.ans_ex, 32'd12);

        // load x5, then a dependent ADD: one stall, one bubble, then MEM forwarding
        s = mk(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h100, 5'd5);
        s.sd = 1'b1; s.en = 1'b1;
        step(s);
        u = mk(ALU_ADD, 5'd5, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd6);
        step(u);
        #1 chk("lu_stall", 32'(bus.stall_out), 32'd1);
        after_edge();
        chk("lu_bubble_rw", 32'(bus.rw_out), 32'd0);
        chk("lu_bubble_en", 32'(bus.dm_en), 32'd0);
        u.wb_rw = 5'd5; u.wb_data = 32'h55;
        step(u);
        #1 chk("lu_release", 32'(bus.stall_out), 32'd0);
        after_edge();
        chk("lu_ans", bus.ans_ex, 32'h55);

        // SRA by 4, then a consumer forwarding the shifted value
        step(mk(ALU_SRA, 5'd8, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd4, 5'd9));
        issue(mk(ALU_ADD, 5'd9, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd10));
        after_edge();
        chk("sra_fwd", bus.ans_ex, 32'hF800_0000);

        // zero-amount shift and compares
        step(mk(ALU_SLL, 5'd11, 32'h1234, 5'd0, 32'd0, 1'b1, 32'd0, 5'd12));
        #1 chk("sll0_nostall", 32'(bus.stall_out), 32'd0);
        after_edge();
        chk("sll0_ans", bus.ans_ex, 32'h1234);
        step(mk(ALU_SLTU, 5'd11, 32'd1, 5'd14, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd13));
        after_edge();
        chk("sltu", bus.ans_ex, 32'd1);
        step(mk(ALU_SLT, 5'd11, 32'd1, 5'd14, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd13));
        after_edge();
        chk("slt", bus.ans_ex, 32'd0);

        // SRL by 31 flushed in its third shift cycle
        step(mk(ALU_SRL, 5'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 32'd31, 5'd15));
        step(idle()); step(idle());
        s = idle(); s.flush = 1'b1;
        step(s);
        step(idle());
        #1 chk("flush_stall", 32'(bus.stall_out), 32'd0);
        for (int i = 0; i < 33; i++) step(idle());

        // reset in the middle of a shift
        step(mk(ALU_SRL, 5'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 32'd31, 5'd15));
        step(idle()); step(idle());
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());
        #1 chk("rst_stall", 32'(bus.stall_out), 32'd0);
        for (int i = 0; i < 33; i++) step(idle());

        for (int n = 0; n < 250; n++) begin
            s = rnd();
            if ($urandom_range(0, 19) == 0) begin
                s.flush = 1'b1;
                step(s);
            end else if ($urandom_range(0, 9) == 0) begin
                s.valid = 1'b0;
                step(s);
            end else begin
                issue(s);
            end
        end
        for (int i = 0; i < 3; i++) step(idle());
        after_edge();
        #2;
        chk("drain_out", 32'(exp_out_q.size()), 32'd0);
        chk("drain_stall", 32'(exp_stall_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
